// File: rtl/stream_mask_pkg.sv
// Shared types and default widths for the stream word-mask controller.
// Imported by the controller top and kept free of any logic.
package stream_mask_pkg;

   localparam int STREAM_DATA_W = 32;
   localparam int STREAM_LEN_W  = 16;
   localparam logic [STREAM_DATA_W-1:0] STREAM_DEFAULT_MASK = 32'h0000_ffff;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } mask_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready register slice: an output register plus one skid entry.
// in_ready is taken straight from the skid flop, so the upstream path is fully registered.
module axis_skid_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         empty
);

   logic         out_valid_reg, out_valid_next;
   logic [W-1:0] out_data_reg, out_data_next;
   logic         skid_valid_reg, skid_valid_next;
   logic [W-1:0] skid_data_reg, skid_data_next;
   logic         in_fire;

   assign in_ready  = !skid_valid_reg;
   assign in_fire   = in_valid && !skid_valid_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign empty     = !out_valid_reg && !skid_valid_reg;

   always_comb begin
      out_valid_next  = out_valid_reg;
      out_data_next   = out_data_reg;
      skid_valid_next = skid_valid_reg;
      skid_data_next  = skid_data_reg;
      if (!out_valid_reg || out_ready) begin
         // Output register is free this cycle: refill from skid first to keep order.
         if (skid_valid_reg) begin
            out_valid_next  = 1'b1;
            out_data_next   = skid_data_reg;
            skid_valid_next = 1'b0;
         end else begin
            out_valid_next = in_fire;
            if (in_fire) begin
               out_data_next = in_data;
            end
         end
      end else if (in_fire) begin
         skid_valid_next = 1'b1;
         skid_data_next  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else begin
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         skid_valid_reg <= skid_valid_next;
         skid_data_reg  <= skid_data_next;
      end
   end

endmodule

// File: rtl/stream_mask_ctrl.sv
// Word-mask sequencer between MM2S and the FFT input: masks each word, counts
// words into fixed-length frames for TLAST, and re-samples config only at frame boundaries.
module stream_mask_ctrl
   import stream_mask_pkg::*;
#(
   parameter int                DATA_W       = STREAM_DATA_W,
   parameter int                LEN_W        = STREAM_LEN_W,
   parameter logic [DATA_W-1:0] DEFAULT_MASK = STREAM_DEFAULT_MASK
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              cfg_enable,
   input  logic [DATA_W-1:0] cfg_mask,
   input  logic [LEN_W-1:0]  cfg_frame_len,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [LEN_W-1:0]  frame_count,
   output logic              busy
);

   mask_state_t       state_reg, state_next;
   logic [DATA_W-1:0] mask_reg, mask_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [LEN_W-1:0]  word_idx_reg, word_idx_next;
   logic [LEN_W-1:0]  frame_count_reg, frame_count_next;

   logic              input_open;
   logic              accept;
   logic              is_last;
   logic              slice_in_ready;
   logic              slice_empty;
   logic [DATA_W-1:0] masked_data;
   logic [DATA_W:0]   slice_out;

   // In DRAIN a zero word index means the frame's last word is already in.
   assign input_open    = (state_reg == RUN) || ((state_reg == DRAIN) && (word_idx_reg != '0));
   assign s_axis_tready = input_open && slice_in_ready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign is_last       = (word_idx_reg == (len_reg - LEN_W'(1)));
   assign busy          = (state_reg != IDLE);
   assign frame_count   = frame_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_mask
         assign masked_data[gi] = s_axis_tdata[gi] & mask_reg[gi];
      end
   endgenerate

   axis_skid_buf #(
      .W (DATA_W + 1)
   ) u_slice (
      .clk       (aclk),
      .rst_n     (aresetn),
      .in_valid  (accept),
      .in_data   ({is_last, masked_data}),
      .in_ready  (slice_in_ready),
      .out_valid (m_axis_tvalid),
      .out_data  (slice_out),
      .out_ready (m_axis_tready),
      .empty     (slice_empty)
   );

   assign m_axis_tlast = slice_out[DATA_W];
   assign m_axis_tdata = slice_out[DATA_W-1:0];

   always_comb begin
      state_next       = state_reg;
      mask_next        = mask_reg;
      len_next         = len_reg;
      word_idx_next    = word_idx_reg;
      frame_count_next = frame_count_reg;

      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         frame_count_next = frame_count_reg + LEN_W'(1);
      end

      if (accept) begin
         if (is_last) begin
            // Boundary: new config governs the next word; a zero length is ignored.
            word_idx_next = '0;
            mask_next     = cfg_mask;
            if (cfg_frame_len != '0) begin
               len_next = cfg_frame_len;
            end
         end else begin
            word_idx_next = word_idx_reg + LEN_W'(1);
         end
      end

      case (state_reg)
         IDLE: begin
            if (cfg_enable && (cfg_frame_len != '0)) begin
               state_next    = RUN;
               mask_next     = cfg_mask;
               len_next      = cfg_frame_len;
               word_idx_next = '0;
            end
         end
         RUN: begin
            if (!cfg_enable) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if ((word_idx_reg == '0) && slice_empty) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg       <= IDLE;
         mask_reg        <= DEFAULT_MASK;
         len_reg         <= '0;
         word_idx_reg    <= '0;
         frame_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         mask_reg        <= mask_next;
         len_reg         <= len_next;
         word_idx_reg    <= word_idx_next;
         frame_count_reg <= frame_count_next;
      end
   end

endmodule

// File: tb/tb_stream_mask_ctrl.sv
// Directed self-checking bench for stream_mask_ctrl; one task per scenario,
// expected words worked out by hand from the input pattern and mask.
module tb_stream_mask_ctrl;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [31:0] cfg_mask = 32'h0000_ffff;
   logic [15:0] cfg_frame_len = 16'd0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic [15:0] frame_count;
   logic        busy;

   int checks = 0;
   int failures = 0;
   bit verbose = 1'b1;

   logic [31:0] out_data_q[$];
   logic        out_last_q[$];

   stream_mask_ctrl dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_enable    (cfg_enable),
      .cfg_mask      (cfg_mask),
      .cfg_frame_len (cfg_frame_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .frame_count   (frame_count),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Output handshakes land on the following rising edge.
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         out_data_q.push_back(m_axis_tdata);
         out_last_q.push_back(m_axis_tlast);
         if (verbose) begin
            $display("OUT data=%08h last=%0b frame_count_before=%0d", m_axis_tdata, m_axis_tlast, frame_count);
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_out();
      out_data_q.delete();
      out_last_q.delete();
   endtask

   task automatic drive_word(input logic [31:0] w);
      bit done;
      done = 1'b0;
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge aclk);
         if (s_axis_tready === 1'b1) begin
            @(posedge aclk);
            #1;
            done = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL accept_timeout word=%08h got=not_accepted exp=accepted", w);
      end
   endtask

   task automatic wait_out(input int n);
      int c;
      c = 0;
      while (out_data_q.size() < n && c < 500) begin
         tick();
         c++;
      end
      checks++;
      if (out_data_q.size() < n) begin
         failures++;
         $display("FAIL out_timeout got=%0d exp=%0d", out_data_q.size(), n);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (busy !== 1'b0 && c < 500) begin
         tick();
         c++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_timeout got_busy=%0b exp=0", busy);
      end
   endtask

   task automatic restart(input logic [31:0] mask, input logic [15:0] len);
      m_axis_tready = 1'b1;
      cfg_enable    = 1'b0;
      wait_idle();
      cfg_mask      = mask;
      cfg_frame_len = len;
      cfg_enable    = 1'b1;
      tick();
      clear_out();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got=%0b%0b%0b exp=000", s_axis_tready, m_axis_tvalid, m_axis_tlast);
      end
      checks++;
      if (m_axis_tdata !== 32'd0 || frame_count !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_values got=%08h/%0d/%0b exp=00000000/0/0", m_axis_tdata, frame_count, busy);
      end
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle got=%0b%0b exp=00", busy, s_axis_tready);
      end
   endtask

   task automatic test_basic_frame();
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_l;
      m_axis_tready = 1'b1;
      cfg_mask      = 32'h0000_ffff;
      cfg_frame_len = 16'd4;
      clear_out();
      cfg_enable    = 1'b1;
      @(negedge aclk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL startup_early got_busy=%0b exp=0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || s_axis_tready !== 1'b1) begin
         failures++;
         $display("FAIL startup got=%0b%0b exp=11", busy, s_axis_tready);
      end
      for (int i = 0; i < 4; i++) drive_word(32'haaaa_1111 + 32'(i));
      wait_out(4);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_d = 32'h0000_1111 + 32'(i);
         got_d = (i < out_data_q.size()) ? out_data_q[i] : 32'hx;
         got_l = (i < out_last_q.size()) ? out_last_q[i] : 1'bx;
         checks++;
         if (got_d !== exp_d || got_l !== (i == 3)) begin
            failures++;
            $display("FAIL basic_word%0d got=%08h/%0b exp=%08h/%0b", i, got_d, got_l, exp_d, (i == 3));
         end
      end
      checks++;
      if (frame_count !== 16'd1) begin
         failures++;
         $display("FAIL basic_frame_count got=%0d exp=1", frame_count);
      end
   endtask

   task automatic test_cfg_change();
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_l;
      logic [15:0] hi;
      logic [15:0] lo;
      clear_out();
      for (int i = 0; i < 8; i++) begin
         if (i == 2) cfg_mask = 32'hffff_0000;
         hi = 16'h1000 + 16'(i);
         lo = 16'h2000 + 16'(i);
         drive_word({hi, lo});
      end
      wait_out(8);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         hi = 16'h1000 + 16'(i);
         lo = 16'h2000 + 16'(i);
         exp_d = (i < 4) ? {16'h0000, lo} : {hi, 16'h0000};
         got_d = (i < out_data_q.size()) ? out_data_q[i] : 32'hx;
         got_l = (i < out_last_q.size()) ? out_last_q[i] : 1'bx;
         checks++;
         if (got_d !== exp_d || got_l !== (i == 3 || i == 7)) begin
            failures++;
            $display("FAIL cfg_word%0d got=%08h/%0b exp=%08h/%0b", i, got_d, got_l, exp_d, (i == 3 || i == 7));
         end
      end
      checks++;
      if (frame_count !== 16'd3) begin
         failures++;
         $display("FAIL cfg_frame_count got=%0d exp=3", frame_count);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_l;
      logic [3:0]  pat;
      restart(32'h00ff_00ff, 16'd8);
      pat = 4'b1001;
      fork
         begin
            for (int i = 0; i < 8; i++) drive_word(32'h1122_3340 + 32'(i));
         end
         begin
            bit          pv;
            bit          pr;
            bit          psv;
            logic        plast;
            logic [31:0] pd;
            pv = 1'b0; pr = 1'b0; psv = 1'b0; plast = 1'b0; pd = 32'd0;
            for (int c = 0; c < 40; c++) begin
               @(posedge aclk);
               #1;
               m_axis_tready = pat[c % 4];
               @(negedge aclk);
               if (pv && !pr) begin
                  checks++;
                  if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== plast) begin
                     failures++;
                     $display("FAIL bp_hold got=%0b/%08h/%0b exp=1/%08h/%0b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, plast);
                  end
               end
               if (pv && !pr && psv) begin
                  checks++;
                  if (s_axis_tready !== 1'b0) begin
                     failures++;
                     $display("FAIL bp_tready_low got=%0b exp=0", s_axis_tready);
                  end
               end
               pv = m_axis_tvalid; pr = m_axis_tready; psv = s_axis_tvalid;
               pd = m_axis_tdata; plast = m_axis_tlast;
            end
         end
      join
      m_axis_tready = 1'b1;
      wait_out(8);
      tick();
      tick();
      tick();
      checks++;
      if (out_data_q.size() != 8) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=8", out_data_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         exp_d = 32'h0022_0040 + 32'(i);
         got_d = (i < out_data_q.size()) ? out_data_q[i] : 32'hx;
         got_l = (i < out_last_q.size()) ? out_last_q[i] : 1'bx;
         checks++;
         if (got_d !== exp_d || got_l !== (i == 7)) begin
            failures++;
            $display("FAIL bp_word%0d got=%08h/%0b exp=%08h/%0b", i, got_d, got_l, exp_d, (i == 7));
         end
      end
      checks++;
      if (frame_count !== 16'd4) begin
         failures++;
         $display("FAIL bp_frame_count got=%0d exp=4", frame_count);
      end
   endtask

   task automatic test_disable_mid_frame();
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_l;
      restart(32'hffff_ffff, 16'd4);
      drive_word(32'hbeef_0000);
      drive_word(32'hbeef_0001);
      cfg_enable = 1'b0;
      drive_word(32'hbeef_0002);
      drive_word(32'hbeef_0003);
      @(negedge aclk);
      checks++;
      if (s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL dis_input_closed got=%0b exp=0", s_axis_tready);
      end
      wait_idle();
      tick();
      checks++;
      if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL dis_idle got=%0b%0b exp=00", busy, s_axis_tready);
      end
      for (int i = 0; i < 4; i++) begin
         exp_d = 32'hbeef_0000 + 32'(i);
         got_d = (i < out_data_q.size()) ? out_data_q[i] : 32'hx;
         got_l = (i < out_last_q.size()) ? out_last_q[i] : 1'bx;
         checks++;
         if (got_d !== exp_d || got_l !== (i == 3)) begin
            failures++;
            $display("FAIL dis_word%0d got=%08h/%0b exp=%08h/%0b", i, got_d, got_l, exp_d, (i == 3));
         end
      end
      checks++;
      if (frame_count !== 16'd5) begin
         failures++;
         $display("FAIL dis_frame_count got=%0d exp=5", frame_count);
      end
   endtask

   task automatic test_zero_len_and_len1();
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_l;
      logic [3:0]  nib;
      int          not_last;
      m_axis_tready = 1'b1;
      cfg_mask      = 32'hf0f0_f0f0;
      cfg_frame_len = 16'd0;
      cfg_enable    = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL zero_len_idle got=%0b%0b exp=00", busy, s_axis_tready);
      end
      cfg_frame_len = 16'd1;
      tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL len1_start got_busy=%0b exp=1", busy);
      end
      clear_out();
      for (int i = 0; i < 4; i++) begin
         nib = 4'(i + 1);
         drive_word({8{nib}});
      end
      wait_out(4);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         nib = 4'(i + 1);
         exp_d = {4{nib, 4'h0}};
         got_d = (i < out_data_q.size()) ? out_data_q[i] : 32'hx;
         got_l = (i < out_last_q.size()) ? out_last_q[i] : 1'bx;
         checks++;
         if (got_d !== exp_d || got_l !== 1'b1) begin
            failures++;
            $display("FAIL len1_word%0d got=%08h/%0b exp=%08h/1", i, got_d, got_l, exp_d);
         end
      end
      checks++;
      if (frame_count !== 16'd9) begin
         failures++;
         $display("FAIL len1_frame_count got=%0d exp=9", frame_count);
      end
      verbose = 1'b0;
      for (int n = 0; n < 65526; n++) drive_word(32'h5555_aaaa ^ 32'(n));
      wait_out(4 + 65526);
      tick();
      tick();
      verbose = 1'b1;
      not_last = 0;
      foreach (out_last_q[k]) if (out_last_q[k] !== 1'b1) not_last++;
      checks++;
      if (not_last != 0) begin
         failures++;
         $display("FAIL len1_all_last got_not_last=%0d exp=0", not_last);
      end
      checks++;
      if (frame_count !== 16'hffff) begin
         failures++;
         $display("FAIL wrap_pre got=%04h exp=ffff", frame_count);
      end
      clear_out();
      drive_word(32'h0f0f_0f0f);
      wait_out(1);
      tick();
      tick();
      checks++;
      if (frame_count !== 16'h0000) begin
         failures++;
         $display("FAIL wrap_post got=%04h exp=0000", frame_count);
      end
   endtask

   task automatic test_async_reset();
      restart(32'hffff_ffff, 16'd1);
      drive_word(32'h1234_5678);
      wait_out(1);
      tick();
      tick();
      checks++;
      if (frame_count !== 16'd1) begin
         failures++;
         $display("FAIL ar_pre_count got=%0d exp=1", frame_count);
      end
      m_axis_tready = 1'b0;
      clear_out();
      drive_word(32'hcafe_f00d);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hcafe_f00d || m_axis_tlast !== 1'b1) begin
         failures++;
         $display("FAIL ar_buffered got=%0b/%08h/%0b exp=1/cafef00d/1", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0) begin
         failures++;
         $display("FAIL ar_out_cleared got=%0b/%0b/%08h exp=0/0/00000000", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      checks++;
      if (s_axis_tready !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0) begin
         failures++;
         $display("FAIL ar_ctrl_cleared got=%0b/%0b/%0d exp=0/0/0", s_axis_tready, busy, frame_count);
      end
      cfg_enable = 1'b0;
      tick();
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      checks++;
      if (out_data_q.size() != 0 || frame_count !== 16'd0) begin
         failures++;
         $display("FAIL ar_discard got_out=%0d/count=%0d exp=0/0", out_data_q.size(), frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_cfg_change();
      test_backpressure();
      test_disable_mid_frame();
      test_zero_len_and_len1();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
